genie_pipe_reg: RTL
===================

GENIE_PIPE_REG -- requirements
Module: genie_pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 0: payload width in bits (field plus data), legal range 1 or more.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_data  input  WIDTH  upstream payload.
REQ-005 SHALL have port i_valid  input  1  upstream payload valid.
REQ-006 SHALL have port o_ready  output  1  this block can accept a payload.
REQ-007 SHALL have port o_data  output  WIDTH  downstream payload, feeding the field-conversion stage.
REQ-008 SHALL have port o_valid  output  1  downstream payload valid; drives the conversion stage's i_valid.
REQ-009 SHALL have port i_ready  input  1  downstream accepts the payload.
REQ-010 SHALL have port o_xfer_count  output  16  count of accepted downstream transfers; present only under the configuration macro.

Function
REQ-011 SHALL be a two-entry skid buffer: a main register (drives o_data) and a skid register.
REQ-012 SHALL implement states EMPTY (no entries), ONE (main only) and FULL (main plus skid).
REQ-013 SHALL count a transfer on either side only when valid and ready are both 1 in the same cycle.
REQ-014 SHALL drive o_ready from a register, equal to 1 in EMPTY and ONE and 0 in FULL; it SHALL have no combinational path from i_ready.
REQ-015 SHALL drive o_valid = 1 in ONE and FULL and 0 in EMPTY.
REQ-016 SHALL have one-cycle latency: a payload accepted in EMPTY at cycle N appears on o_data with o_valid=1 in cycle N+1.
REQ-017 SHALL make the following transitions:
- EMPTY, input transfer -> ONE.
- ONE, input transfer only -> FULL (payload into skid).
- ONE, output transfer only -> EMPTY.
- ONE, both transfers -> ONE (new payload into main).
- FULL, output transfer -> ONE (skid moves to main).
- Otherwise, hold.
REQ-018 SHALL sustain one transfer per cycle when i_valid and i_ready stay 1.
REQ-019 SHALL keep o_data stable while o_valid=1 and i_ready=0.
REQ-020 SHALL preserve payload order; no payload is dropped or duplicated.
REQ-021 SHALL ignore i_data whenever i_valid=0 or o_ready=0.
REQ-022 SHALL in simulation assert that o_valid never falls without an output transfer.

Reset
REQ-023 SHALL on reset low, immediately and asynchronously, enter EMPTY with o_valid=0, o_ready=0 and o_xfer_count=0; o_data is don't-care.
REQ-024 SHALL raise o_ready to 1 on the first clk edge after reset deasserts.
REQ-025 SHALL discard both entries if reset asserts while in ONE or FULL.

Configuration
REQ-026 SHALL use macro GENIE_PIPE_REG_STATS_EN.
REQ-027 SHALL, when GENIE_PIPE_REG_STATS_EN is defined:
- provide o_xfer_count, incremented by 1 on each output transfer;
- wrap 0xFFFF to 0x0000.
REQ-028 SHALL, when GENIE_PIPE_REG_STATS_EN is undefined, have neither the port nor the counter logic; all other behaviour is identical.

Structure
REQ-029 SHALL take the state enum (EMPTY, ONE, FULL) and the counter width constant (16) from shared package genie_pkg.
REQ-030 SHALL be a single module with no sub-modules; storage and the FSM are inline.

Verification
REQ-031 SHALL cover: reset low mid-FULL -> o_valid=0 and o_ready=0 at once; o_ready=1 one edge after release; o_xfer_count=0.
REQ-032 SHALL cover: i_valid=1 and i_ready=1 held, payloads 0x01..0x08 -> o_data 0x01..0x08 in consecutive cycles starting one cycle after the first input, o_ready never 0.
REQ-033 SHALL cover: i_ready=0, two payloads 0xA, 0xB sent -> FULL, o_ready=0, o_data=0xA held; i_ready=1 -> 0xA then 0xB out, o_ready=1 after the 0xA transfer.
REQ-034 SHALL cover: i_valid=1 with a new value each cycle while o_ready=0 -> those values never appear on o_data.
REQ-035 SHALL cover: in ONE, input and output transfers in the same cycle -> stays ONE, o_data takes the new payload next cycle.
REQ-036 SHALL cover: with GENIE_PIPE_REG_STATS_EN defined, 65537 transfers -> o_xfer_count=1.

Source files
------------

// File: rtl/genie_pkg.sv
// genie_pkg -- shared types and constants for the genie pipeline blocks.
// Holds the skid-buffer occupancy enum and the transfer-counter width.
`timescale 1ns/1ps

package genie_pkg;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no entries held
        ONE   = 2'd1,   // main register holds a payload
        FULL  = 2'd2    // main and skid registers both hold payloads
    } pipe_state_e;

    // Width of the optional accepted-transfer statistics counter.
    localparam int XFER_CNT_W = 16;

endpackage : genie_pkg

// File: rtl/genie_pipe_reg.sv
// genie_pipe_reg -- two-entry skid buffer (pipeline register) with a fully
// registered o_ready, so there is no combinational path from i_ready upstream.
//
// The main register drives o_data. The skid register catches the one payload
// that can arrive in the cycle the downstream stalls while o_ready is still 1.
//
// Optional feature: define GENIE_PIPE_REG_STATS_EN to add o_xfer_count, a
// 16-bit wrapping count of accepted downstream transfers.
`timescale 1ns/1ps

module genie_pipe_reg
    import genie_pkg::*;
#(
    parameter int  WIDTH = 0,
    // The default WIDTH of 0 is outside the legal range; clamp to one bit so
    // the port ranges stay well formed when the block is elaborated unset.
    localparam int DW    = (WIDTH > 0) ? WIDTH : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DW-1:0]         i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DW-1:0]         o_data,
    output logic                  o_valid,
    input  logic                  i_ready
`ifdef GENIE_PIPE_REG_STATS_EN
    ,
    output logic [XFER_CNT_W-1:0] o_xfer_count
`endif
);

    pipe_state_e   state_q;
    logic          ready_q;
    logic          valid_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    // Handshakes only count when valid and ready are both high together.
    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = i_valid & ready_q;
    assign out_xfer = valid_q & i_ready;

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_data   = main_q;

    // Occupancy FSM with registered ready/valid outputs derived from the next state.
    // NOTE: every register here uses <= so all state updates see the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    // o_ready rises on the first edge after reset release.
                    ready_q <= 1'b1;
                    if (in_xfer) begin
                        state_q <= ONE;
                        valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_q <= FULL;
                        ready_q <= 1'b0;
                    end else if (!in_xfer && out_xfer) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    // o_ready is low here, so only the output side can move.
                    if (out_xfer) begin
                        state_q <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Payload storage: load main or skid on input transfers, refill main from skid.
    // NOTE: payload registers are deliberately not reset; o_valid qualifies them.
    always_ff @(posedge clk) begin
        case (state_q)
            EMPTY: begin
                if (in_xfer) main_q <= i_data;
            end
            ONE: begin
                if (in_xfer && out_xfer) main_q <= i_data;
                else if (in_xfer)        skid_q <= i_data;
            end
            FULL: begin
                if (out_xfer) main_q <= skid_q;
            end
            default: ;
        endcase
    end

`ifdef GENIE_PIPE_REG_STATS_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_q;

    // Count accepted downstream transfers; wraps naturally from all-ones to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) xfer_cnt_q <= '0;
        else if (out_xfer) xfer_cnt_q <= xfer_cnt_q + 1'b1;
    end

    assign o_xfer_count = xfer_cnt_q;
`endif

    // A presented payload may only be withdrawn by being accepted downstream.
    a_valid_held: assert property (
        @(posedge clk) disable iff (!reset)
        (valid_q && !i_ready) |=> valid_q
    ) else $error("o_valid fell without an output transfer");

endmodule : genie_pipe_reg
